// File: rtl/aq_memcpy_pkg.sv
// Shared types and helpers for the aq_memcpy_sched command scheduler.
package aq_memcpy_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StCalc,
    StRdIssue,
    StRdWait,
    StWrIssue,
    StWrWait,
    StDone
  } state_e;

  localparam logic [31:0] PAGE_BYTES = 32'h1000;

  // Largest chunk that fits the burst limit and stays inside both 4 KB pages.
  function automatic logic [31:0] chunk_min(input logic [31:0] remaining,
                                            input logic [31:0] burst_bytes,
                                            input logic [11:0] src_off,
                                            input logic [11:0] dst_off);
    logic [31:0] c;
    logic [31:0] src_left;
    logic [31:0] dst_left;
    src_left = PAGE_BYTES - {20'd0, src_off};
    dst_left = PAGE_BYTES - {20'd0, dst_off};
    c = remaining;
    if (burst_bytes < c) c = burst_bytes;
    if (src_left < c) c = src_left;
    if (dst_left < c) c = dst_left;
    return c;
  endfunction

endpackage

// File: rtl/aq_memcpy_rr_arb.sv
// Combinational round-robin arbiter: first requester strictly after the pointer, wrapping.
module aq_memcpy_rr_arb #(
  parameter int unsigned CH_NUM = 4
) (
  input  logic [CH_NUM-1:0] req_i,
  input  logic [2:0]        ptr_i,
  output logic [CH_NUM-1:0] grant_o,
  output logic [2:0]        idx_o,
  output logic              valid_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 1; i <= CH_NUM; i++) begin
      for (int unsigned j = 0; j < CH_NUM; j++) begin
        if (!valid_o && req_i[j] && (j == (32'(ptr_i) + i) % CH_NUM)) begin
          valid_o    = 1'b1;
          grant_o[j] = 1'b1;
          idx_o      = 3'(j);
        end
      end
    end
  end

endmodule

// File: rtl/aq_memcpy_sched.sv
// Multi-channel memcpy scheduler: round-robin command intake, 4 KB / burst-limited chunking.
// Optional statistics outputs enabled by defining AQ_MEMCPY_SCHED_STAT_EN.
module aq_memcpy_sched
  import aq_memcpy_pkg::*;
#(
  parameter int unsigned CH_NUM    = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_BURST = 256
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [CH_NUM-1:0]        CMD_REQ,
  output logic [CH_NUM-1:0]        CMD_READY,
  output logic [CH_NUM-1:0]        CMD_DONE,
  input  logic [CH_NUM*ADDR_W-1:0] CMD_DST,
  input  logic [CH_NUM*ADDR_W-1:0] CMD_SRC,
  input  logic [CH_NUM*32-1:0]     CMD_LEN,
  output logic                     RD_START,
  output logic [ADDR_W-1:0]        RD_ADRS,
  output logic [31:0]              RD_COUNT,
  input  logic                     RD_READY,
  output logic                     WR_START,
  output logic [ADDR_W-1:0]        WR_ADRS,
  output logic [31:0]              WR_COUNT,
  input  logic                     WR_READY,
  output logic                     FIFO_RST,
  output logic                     BUSY,
`ifdef AQ_MEMCPY_SCHED_STAT_EN
  output logic [2:0]               CUR_CH,
  output logic [31:0]              STAT_BYTES,
  output logic [15:0]              STAT_CMDS
`else
  output logic [2:0]               CUR_CH
`endif
);

  localparam int unsigned BPB         = DATA_W / 8;
  localparam int unsigned AlignW      = $clog2(BPB);
  localparam logic [31:0] BurstBytes  = 32'(MAX_BURST * BPB);
  localparam logic [ADDR_W-1:0] AddrMask = {ADDR_W{1'b1}} << AlignW;
  localparam logic [31:0] LenMask     = 32'hFFFF_FFFF << AlignW;

  state_e              state_q;
  logic [2:0]          ptr_q, cur_ch_q;
  logic [ADDR_W-1:0]   src_q, dst_q, rd_adrs_q, wr_adrs_q;
  logic [31:0]         rem_q, chunk_q;
  logic [CH_NUM-1:0]   cmd_ready_q, cmd_done_q;
  logic                rd_start_q, wr_start_q, fifo_rst_q, busy_q;

  logic [CH_NUM-1:0]   arb_grant;
  logic [2:0]          arb_idx;
  logic                arb_valid;
  logic [ADDR_W-1:0]   sel_src, sel_dst;
  logic [31:0]         sel_len, chunk;
  logic [CH_NUM-1:0]   done_oh;

  aq_memcpy_rr_arb #(
    .CH_NUM(CH_NUM)
  ) u_arb (
    .req_i  (CMD_REQ),
    .ptr_i  (ptr_q),
    .grant_o(arb_grant),
    .idx_o  (arb_idx),
    .valid_o(arb_valid)
  );

  always_comb begin
    sel_src = '0;
    sel_dst = '0;
    sel_len = '0;
    done_oh = '0;
    for (int unsigned j = 0; j < CH_NUM; j++) begin
      if (cur_ch_q == 3'(j)) begin
        sel_src    = CMD_SRC[j*ADDR_W +: ADDR_W] & AddrMask;
        sel_dst    = CMD_DST[j*ADDR_W +: ADDR_W] & AddrMask;
        sel_len    = CMD_LEN[j*32 +: 32] & LenMask;
        done_oh[j] = 1'b1;
      end
    end
  end

  assign chunk = chunk_min(rem_q, BurstBytes, src_q[11:0], dst_q[11:0]);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cur_ch_q    <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      chunk_q     <= '0;
      rd_adrs_q   <= '0;
      wr_adrs_q   <= '0;
      cmd_ready_q <= '0;
      cmd_done_q  <= '0;
      rd_start_q  <= 1'b0;
      wr_start_q  <= 1'b0;
      fifo_rst_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cmd_ready_q <= '0;
      cmd_done_q  <= '0;
      rd_start_q  <= 1'b0;
      wr_start_q  <= 1'b0;
      fifo_rst_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            cur_ch_q    <= arb_idx;
            cmd_ready_q <= arb_grant;
            fifo_rst_q  <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StAccept;
          end
        end
        StAccept: begin
          src_q <= sel_src;
          dst_q <= sel_dst;
          rem_q <= sel_len;
          ptr_q <= cur_ch_q;
          if (sel_len == '0) begin
            cmd_done_q <= done_oh;
            busy_q     <= 1'b0;
            state_q    <= StDone;
          end else begin
            state_q <= StCalc;
          end
        end
        StCalc: begin
          rd_adrs_q <= src_q;
          wr_adrs_q <= dst_q;
          chunk_q   <= chunk;
          state_q   <= StRdIssue;
        end
        StRdIssue: begin
          if (RD_READY) begin
            rd_start_q <= 1'b1;
            state_q    <= StRdWait;
          end
        end
        // READY is still stale while the start pulse is on the wire.
        StRdWait: begin
          if (!rd_start_q && RD_READY) state_q <= StWrIssue;
        end
        StWrIssue: begin
          if (WR_READY) begin
            wr_start_q <= 1'b1;
            state_q    <= StWrWait;
          end
        end
        StWrWait: begin
          if (!wr_start_q && WR_READY) begin
            src_q <= src_q + ADDR_W'(chunk_q);
            dst_q <= dst_q + ADDR_W'(chunk_q);
            rem_q <= rem_q - chunk_q;
            if (rem_q == chunk_q) begin
              cmd_done_q <= done_oh;
              busy_q     <= 1'b0;
              state_q    <= StDone;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign CMD_READY = cmd_ready_q;
  assign CMD_DONE  = cmd_done_q;
  assign RD_START  = rd_start_q;
  assign RD_ADRS   = rd_adrs_q;
  assign RD_COUNT  = chunk_q;
  assign WR_START  = wr_start_q;
  assign WR_ADRS   = wr_adrs_q;
  assign WR_COUNT  = chunk_q;
  assign FIFO_RST  = fifo_rst_q;
  assign BUSY      = busy_q;
  assign CUR_CH    = cur_ch_q;

`ifdef AQ_MEMCPY_SCHED_STAT_EN
  logic [31:0] stat_bytes_q;
  logic [15:0] stat_cmds_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_bytes_q <= '0;
      stat_cmds_q  <= '0;
    end else begin
      if (wr_start_q) stat_bytes_q <= stat_bytes_q + chunk_q;
      if (|cmd_done_q) stat_cmds_q <= stat_cmds_q + 16'd1;
    end
  end

  assign STAT_BYTES = stat_bytes_q;
  assign STAT_CMDS  = stat_cmds_q;
`endif

endmodule

// File: tb/tb_aq_memcpy_sched.sv
// Randomized scoreboard bench for aq_memcpy_sched with a behavioural engine and copy model.
module tb_aq_memcpy_sched;

  localparam int CH    = 4;
  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int MB    = 256;
  localparam int BPB   = DW / 8;
  localparam int BURST = MB * BPB;

  logic              CLK = 1'b0;
  logic              RST;
  logic [CH-1:0]     CMD_REQ;
  logic [CH-1:0]     CMD_READY, CMD_DONE;
  logic [CH*AW-1:0]  CMD_DST, CMD_SRC;
  logic [CH*32-1:0]  CMD_LEN;
  logic              RD_START, WR_START, RD_READY, WR_READY, FIFO_RST, BUSY;
  logic [AW-1:0]     RD_ADRS, WR_ADRS;
  logic [31:0]       RD_COUNT, WR_COUNT;
  logic [2:0]        CUR_CH;

  always #5 CLK = ~CLK;

  aq_memcpy_sched #(
    .CH_NUM(CH), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)
  ) dut (
    .CLK(CLK), .RST(RST), .CMD_REQ(CMD_REQ), .CMD_READY(CMD_READY), .CMD_DONE(CMD_DONE),
    .CMD_DST(CMD_DST), .CMD_SRC(CMD_SRC), .CMD_LEN(CMD_LEN),
    .RD_START(RD_START), .RD_ADRS(RD_ADRS), .RD_COUNT(RD_COUNT), .RD_READY(RD_READY),
    .WR_START(WR_START), .WR_ADRS(WR_ADRS), .WR_COUNT(WR_COUNT), .WR_READY(WR_READY),
    .FIFO_RST(FIFO_RST), .BUSY(BUSY), .CUR_CH(CUR_CH)
  );

  typedef struct {
    logic [31:0] adrs;
    logic [31:0] cnt;
    int          ch;
  } chunk_t;

  chunk_t      exp_rd[$];
  chunk_t      exp_wr[$];
  int          exp_ready[$];
  int          exp_done[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          ptr_m = 0;
  bit          mon_en = 1'b0;
  bit          rd_out = 1'b0;
  logic [31:0] b_src[CH], b_dst[CH], b_len[CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flush_model();
    exp_rd.delete();
    exp_wr.delete();
    exp_ready.delete();
    exp_done.delete();
    rd_out = 1'b0;
  endtask

  // Reference: a copy is a byte range split greedily at page and burst limits.
  task automatic model_cmd(input int ch);
    logic [31:0] s, d, rem, c, sl, dl;
    s   = b_src[ch] & ~32'(BPB - 1);
    d   = b_dst[ch] & ~32'(BPB - 1);
    rem = b_len[ch] & ~32'(BPB - 1);
    exp_ready.push_back(ch);
    while (rem != 0) begin
      sl = 4096 - (s % 4096);
      dl = 4096 - (d % 4096);
      c  = rem;
      if (32'(BURST) < c) c = 32'(BURST);
      if (sl < c) c = sl;
      if (dl < c) c = dl;
      exp_rd.push_back('{adrs: s, cnt: c, ch: ch});
      exp_wr.push_back('{adrs: d, cnt: c, ch: ch});
      s   = s + c;
      d   = d + c;
      rem = rem - c;
    end
    exp_done.push_back(ch);
  endtask

  task automatic issue_batch(input logic [CH-1:0] mask);
    logic [CH-1:0] pend;
    int c;
    pend = mask;
    while (pend != 0) begin
      for (int i = 1; i <= CH; i++) begin
        c = (ptr_m + i) % CH;
        if (pend[c]) begin
          model_cmd(c);
          ptr_m   = c;
          pend[c] = 1'b0;
          break;
        end
      end
    end
    @(posedge CLK);
    #1;
    for (int ch = 0; ch < CH; ch++) begin
      CMD_SRC[ch*AW +: AW] = b_src[ch];
      CMD_DST[ch*AW +: AW] = b_dst[ch];
      CMD_LEN[ch*32 +: 32] = b_len[ch];
    end
    CMD_REQ = mask;
  endtask

  task automatic wait_batch();
    for (int cyc = 0; ; cyc++) begin
      @(negedge CLK);
      CMD_REQ = CMD_REQ & ~CMD_READY;
      if (CMD_REQ == 0 && exp_ready.size() == 0 && exp_rd.size() == 0 &&
          exp_wr.size() == 0 && exp_done.size() == 0 && !BUSY) break;
      if (cyc > 20000) begin
        n_vec++;
        n_err++;
        $display("FAIL batch_timeout: got %0d cycles required completion", cyc);
        flush_model();
        CMD_REQ = '0;
        break;
      end
    end
  endtask

  task automatic run_batch(input logic [CH-1:0] mask);
    issue_batch(mask);
    wait_batch();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pulses"}, {RD_START, WR_START, FIFO_RST, BUSY, CMD_READY, CMD_DONE}, 0);
    check({tag, "_rd_adrs"}, RD_ADRS, 0);
    check({tag, "_wr_adrs"}, WR_ADRS, 0);
    check({tag, "_count"}, {RD_COUNT, WR_COUNT}, 0);
    check({tag, "_cur_ch"}, CUR_CH, 0);
  endtask

  // Engine model: READY drops the cycle after START is seen, returns after random latency.
  initial begin
    RD_READY = 1'b1;
    forever begin
      @(negedge CLK);
      if (RD_START === 1'b1) begin
        @(posedge CLK);
        #1 RD_READY = 1'b0;
        repeat ($urandom_range(1, 6)) @(posedge CLK);
        #1 RD_READY = 1'b1;
      end
    end
  end

  initial begin
    WR_READY = 1'b1;
    forever begin
      @(negedge CLK);
      if (WR_START === 1'b1) begin
        @(posedge CLK);
        #1 WR_READY = 1'b0;
        repeat ($urandom_range(1, 6)) @(posedge CLK);
        #1 WR_READY = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    chunk_t e;
    int     c;
    forever begin
      @(negedge CLK);
      if (mon_en && !RST) begin
        if (CMD_READY != 0 || FIFO_RST) begin
          check("fifo_rst_vs_ready", FIFO_RST, CMD_READY != 0);
          if (CMD_READY != 0) begin
            if (exp_ready.size() == 0) check("unexpected_ready", CMD_READY, 0);
            else begin
              c = exp_ready.pop_front();
              check("cmd_ready", CMD_READY, 1 << c);
              check("cur_ch_accept", CUR_CH, c);
              check("busy_accept", BUSY, 1);
            end
          end
        end
        if (RD_START) begin
          if (exp_rd.size() == 0) check("unexpected_rd_start", RD_START, 0);
          else begin
            e = exp_rd.pop_front();
            check("rd_adrs", RD_ADRS, e.adrs);
            check("rd_count", RD_COUNT, e.cnt);
            check("rd_ch", CUR_CH, e.ch);
            check("rd_without_wr", rd_out, 0);
            rd_out = 1'b1;
          end
        end
        if (WR_START) begin
          if (exp_wr.size() == 0) check("unexpected_wr_start", WR_START, 0);
          else begin
            e = exp_wr.pop_front();
            check("wr_adrs", WR_ADRS, e.adrs);
            check("wr_count", WR_COUNT, e.cnt);
            check("wr_ch", CUR_CH, e.ch);
            check("wr_after_rd", rd_out, 1);
            rd_out = 1'b0;
          end
        end
        if (CMD_DONE != 0) begin
          if (exp_done.size() == 0) check("unexpected_done", CMD_DONE, 0);
          else begin
            c = exp_done.pop_front();
            check("cmd_done", CMD_DONE, 1 << c);
            check("busy_done", BUSY, 0);
          end
        end
      end
    end
  end

  initial begin
    bit found;
    int mode;
    RST     = 1'b1;
    CMD_REQ = '0;
    CMD_SRC = '0;
    CMD_DST = '0;
    CMD_LEN = '0;
    for (int ch = 0; ch < CH; ch++) begin
      b_src[ch] = '0;
      b_dst[ch] = '0;
      b_len[ch] = '0;
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_idle_outputs("reset");
    @(posedge CLK);
    #1 RST = 1'b0;
    mon_en = 1'b1;

    b_src[0] = 32'h1000; b_dst[0] = 32'h2000; b_len[0] = 32'h100;
    run_batch(4'b0001);
    b_src[0] = 32'h0FF8; b_dst[0] = 32'h3000; b_len[0] = 32'h20;
    run_batch(4'b0001);
    b_src[0] = 32'h0; b_dst[0] = 32'h10000; b_len[0] = 32'h1800;
    run_batch(4'b0001);

    // Round robin: pointer is at ch0, so ch2 wins before ch0.
    b_src[0] = 32'h5000; b_dst[0] = 32'h6000; b_len[0] = 32'h40;
    b_src[2] = 32'h7000; b_dst[2] = 32'h8000; b_len[2] = 32'h80;
    run_batch(4'b0101);
    run_batch(4'b0100);

    b_src[1] = 32'h9000; b_dst[1] = 32'hA000; b_len[1] = 32'h7;
    run_batch(4'b0010);

    // Reset while the first read of a long copy is outstanding.
    b_src[1] = 32'h4000; b_dst[1] = 32'hC000; b_len[1] = 32'h2000;
    issue_batch(4'b0010);
    found = 1'b0;
    for (int cyc = 0; cyc < 200 && !found; cyc++) begin
      @(negedge CLK);
      found = RD_START;
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL rst_wait_rd_start: got no RD_START required one within 200 cycles");
    end
    @(posedge CLK);
    #1;
    RST     = 1'b1;
    CMD_REQ = '0;
    flush_model();
    ptr_m = 0;
    @(negedge CLK);
    check_idle_outputs("midop_reset");
    repeat (2) begin
      @(negedge CLK);
      check("no_done_in_reset", CMD_DONE, 0);
    end
    @(posedge CLK);
    #1 RST = 1'b0;

    b_src[1] = 32'h2_0010; b_dst[1] = 32'h3_0FF0; b_len[1] = 32'h300;
    b_src[3] = 32'hFFFF_F800; b_dst[3] = 32'h0000_0100; b_len[3] = 32'h1000;
    run_batch(4'b1010);

    for (int it = 0; it < 25; it++) begin
      for (int ch = 0; ch < CH; ch++) begin
        mode = $urandom_range(0, 2);
        b_src[ch] = $urandom;
        b_dst[ch] = $urandom;
        if (mode == 1) b_src[ch] = {b_src[ch][31:12], 12'hF00} | ($urandom & 32'hFF);
        if (mode == 2) b_dst[ch] = 32'hFFFF_F000 | ($urandom & 32'hFFF);
        b_len[ch] = $urandom_range(0, 32'h2400);
      end
      run_batch(4'($urandom_range(1, 15)));
    end

    repeat (5) @(negedge CLK);
    check("queues_drained",
          exp_ready.size() + exp_rd.size() + exp_wr.size() + exp_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
